// File: rtl/mmio_bridge_pkg.sv
// Shared types and constants for the crypto MMIO bridge.
// FSM state codes, error read pattern, default window.
package mmio_bridge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_RD_REQ  = 3'd1;
  localparam state_t S_RD_WAIT = 3'd2;
  localparam state_t S_WR_REQ  = 3'd3;
  localparam state_t S_WR_WAIT = 3'd4;
  localparam state_t S_RESP    = 3'd5;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
  localparam logic [31:0] DEF_BASE  = 32'h4000_0000;
  localparam logic [31:0] DEF_LIMIT = 32'h4000_4FFF;

endpackage

// File: rtl/mmio_byte_merge.sv
// Byte-lane merge: lanes with wstrb set come from new_word.
// Ports: old_word, new_word, wstrb in; merged out.
module mmio_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  wstrb,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// Core load/store port to word-only crypto MMIO bus bridge.
// Ports: clk/rst, req_* (core side), rsp_* (response), m_* (bus).
module mmio_bus_bridge
  import mmio_bridge_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE    = DEF_BASE,
  parameter logic [31:0] PERIPH_LIMIT   = DEF_LIMIT,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_we,
  output logic        m_valid,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [7:0]  cnt;
  logic [31:0] merged;
  logic        in_range;

  assign in_range = (req_addr >= PERIPH_BASE) &&
                    (req_addr <= PERIPH_LIMIT);

  // Held low while rst is asserted so nothing leaks out mid-reset.
  assign req_ready = !rst && (state == S_IDLE);
  assign rsp_valid = !rst && (state == S_RESP);
  assign m_valid   = !rst &&
                     ((state == S_RD_REQ) || (state == S_WR_REQ));

  mmio_byte_merge u_merge (
    .old_word (m_rdata),
    .new_word (r_wdata),
    .wstrb    (r_wstrb),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      cnt       <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_we      <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            if (!in_range) begin
              rsp_rdata <= ERR_RDATA;
              rsp_err   <= 1'b1;
              state     <= S_RESP;
            end else if (req_we && req_wstrb == 4'h0) begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b0;
              state     <= S_RESP;
            end else begin
              m_addr <= {req_addr[31:2], 2'b00};
              if (req_we && req_wstrb == 4'hF) begin
                m_we    <= 1'b1;
                m_wdata <= req_wdata;
                state   <= S_WR_REQ;
              end else begin
                m_we  <= 1'b0;
                state <= S_RD_REQ;
              end
            end
          end
        end
        S_RD_REQ, S_RD_WAIT: begin
          if (m_ready) begin
            if (r_we) begin
              // RMW: read data merges into the pending store
              m_we    <= 1'b1;
              m_wdata <= merged;
              state   <= S_WR_REQ;
            end else begin
              rsp_rdata <= m_rdata;
              rsp_err   <= 1'b0;
              state     <= S_RESP;
            end
          end else if (state == S_RD_REQ) begin
            cnt   <= '0;
            state <= S_RD_WAIT;
          end else if (cnt == TO_LAST) begin
            rsp_rdata <= ERR_RDATA;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WR_REQ, S_WR_WAIT: begin
          if (m_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else if (state == S_WR_REQ) begin
            cnt   <= '0;
            state <= S_WR_WAIT;
          end else if (cnt == TO_LAST) begin
            rsp_rdata <= ERR_RDATA;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Directed bench for mmio_bus_bridge with TIMEOUT_CYCLES=8.
// Vector table plus reset-abort sequence.
module tb_mmio_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic        m_valid;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;

  mmio_bus_bridge #(
    .PERIPH_BASE    (32'h4000_0000),
    .PERIPH_LIMIT   (32'h4000_4FFF),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_we      (m_we),
    .m_valid   (m_valid),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Peripheral: m_ready p_delay cycles after m_valid, -1 = never
  int p_delay = 1;
  int p_cnt = -1;
  always @(posedge clk) begin
    #2;
    m_ready = 1'b0;
    if (rst) begin
      p_cnt = -1;
    end else begin
      if (p_cnt > 0) begin
        p_cnt--;
        if (p_cnt == 0) begin
          m_ready = 1'b1;
          p_cnt = -1;
        end
      end
      if (m_valid && p_delay >= 0) begin
        if (p_delay == 0) m_ready = 1'b1;
        else p_cnt = p_delay;
      end
    end
  end

  // Monitor, sampled mid-cycle
  int          mv_n = 0;
  logic        mv_we = 1'b0;
  logic [31:0] mv_wd = '0;
  logic [31:0] mv_ad = '0;
  int          rsp_n = 0;
  int          rsp_cyc = 0;
  logic [31:0] rsp_rd = '0;
  logic        rsp_er = 1'b0;
  int          acc_cyc = 0;
  always @(negedge clk) begin
    if (m_valid) begin
      mv_n++;
      mv_we = m_we;
      mv_wd = m_wdata;
      mv_ad = m_addr;
    end
    if (rsp_valid) begin
      rsp_n++;
      rsp_cyc = cyc;
      rsp_rd = rsp_rdata;
      rsp_er = rsp_err;
    end
    if (req_valid && req_ready) acc_cyc = cyc;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          dly;
    logic [31:0] prd;
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;
    int          e_mv;
    logic        e_we;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input vec_t v);
    int mv0;
    int rs0;
    bit got;
    mv0 = mv_n;
    rs0 = rsp_n;
    p_delay = v.dly;
    m_rdata = v.prd;
    req_addr = v.addr;
    req_we = v.we;
    req_wdata = v.wdata;
    req_wstrb = v.wstrb;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({v.name, ".busy"}, {31'b0, req_ready}, 32'd0);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (rsp_n > rs0) got = 1;
      else begin @(negedge clk); #1; end
    end
    if (!got) begin
      n_chk++;
      n_err++;
      $display("FAIL %s.no_rsp: got none expected one", v.name);
    end else begin
      chk({v.name, ".rdata"}, rsp_rd, v.e_rd);
      chk({v.name, ".err"}, {31'b0, rsp_er}, {31'b0, v.e_err});
      chk({v.name, ".lat"}, rsp_cyc - acc_cyc, v.e_lat);
    end
    @(posedge clk); #1;
    chk({v.name, ".ready"}, {31'b0, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk({v.name, ".rsp_n"}, rsp_n - rs0, 32'd1);
    chk({v.name, ".mv_n"}, mv_n - mv0, v.e_mv);
    if (v.e_mv > 0) begin
      chk({v.name, ".m_addr"}, mv_ad, {v.addr[31:2], 2'b00});
      chk({v.name, ".m_we"}, {31'b0, mv_we}, {31'b0, v.e_we});
      if (v.e_we) chk({v.name, ".m_wdata"}, mv_wd, v.e_wd);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, ".req_ready"}, {31'b0, req_ready}, 32'd0);
    chk({nm, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({nm, ".m_valid"}, {31'b0, m_valid}, 32'd0);
    chk({nm, ".rsp_rdata"}, rsp_rdata, 32'd0);
    chk({nm, ".rsp_err"}, {31'b0, rsp_err}, 32'd0);
    chk({nm, ".m_addr"}, m_addr, 32'd0);
    chk({nm, ".m_wdata"}, m_wdata, 32'd0);
    chk({nm, ".m_we"}, {31'b0, m_we}, 32'd0);
  endtask

  initial begin
    int mv0;
    int rs0;
    vecs[0]  = '{"ld_basic", 32'h4000_4010, 1'b0, 32'h0, 4'h0, 1,
                 32'h1234_5678, 32'h1234_5678, 1'b0, 3, 1, 1'b0, 32'h0};
    vecs[1]  = '{"st_rmw", 32'h4000_0100, 1'b1, 32'hAABB_CCDD, 4'b0101, 1,
                 32'h1122_3344, 32'h0, 1'b0, 5, 2, 1'b1, 32'h11BB_33DD};
    vecs[2]  = '{"ld_hi_oor", 32'h4000_5000, 1'b0, 32'h0, 4'h0, 1,
                 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 0, 1'b0, 32'h0};
    vecs[3]  = '{"ld_lo_oor", 32'h3FFF_FFFC, 1'b0, 32'h0, 4'h0, 1,
                 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 0, 1'b0, 32'h0};
    vecs[4]  = '{"ld_tmo", 32'h4000_0020, 1'b0, 32'h0, 4'h0, -1,
                 32'h5555_5555, 32'hDEAD_BEEF, 1'b1, 10, 1, 1'b0, 32'h0};
    vecs[5]  = '{"ld_tmo_edge", 32'h4000_0024, 1'b0, 32'h0, 4'h0, 8,
                 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 10, 1, 1'b0, 32'h0};
    vecs[6]  = '{"st_full_fast", 32'h4000_0200, 1'b1, 32'h0102_0304, 4'hF, 0,
                 32'h0, 32'h0, 1'b0, 2, 1, 1'b1, 32'h0102_0304};
    vecs[7]  = '{"st_nostrb", 32'h4000_0300, 1'b1, 32'hFFFF_FFFF, 4'h0, 1,
                 32'h0, 32'h0, 1'b0, 1, 0, 1'b0, 32'h0};
    vecs[8]  = '{"ld_base", 32'h4000_0000, 1'b0, 32'h0, 4'h0, 1,
                 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 3, 1, 1'b0, 32'h0};
    vecs[9]  = '{"ld_limit", 32'h4000_4FFF, 1'b0, 32'h0, 4'h0, 1,
                 32'h7777_0001, 32'h7777_0001, 1'b0, 3, 1, 1'b0, 32'h0};
    vecs[10] = '{"rmw_tmo", 32'h4000_0400, 1'b1, 32'h9999_9999, 4'b1000, -1,
                 32'h0, 32'hDEAD_BEEF, 1'b1, 10, 1, 1'b0, 32'h0};
    vecs[11] = '{"rmw_fast", 32'h4000_0404, 1'b1, 32'hA1B2_C3D4, 4'b0110, 0,
                 32'h5566_7788, 32'h0, 1'b0, 3, 2, 1'b1, 32'h55B2_C388};
    vecs[12] = '{"st_full", 32'h4000_0408, 1'b1, 32'hFEED_FACE, 4'hF, 1,
                 32'h0, 32'h0, 1'b0, 3, 1, 1'b1, 32'hFEED_FACE};
    vecs[13] = '{"st_tmo", 32'h4000_040C, 1'b1, 32'h1357_9BDF, 4'hF, -1,
                 32'h0, 32'hDEAD_BEEF, 1'b1, 10, 1, 1'b1, 32'h1357_9BDF};

    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 1'b0;
    #1;
    chk("reset.ready_after", {31'b0, req_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in RD_WAIT of an RMW store
    mv0 = mv_n;
    rs0 = rsp_n;
    p_delay = -1;
    m_rdata = 32'h1122_3344;
    req_addr = 32'h4000_0500;
    req_we = 1'b1;
    req_wdata = 32'hAABB_CCDD;
    req_wstrb = 4'b0011;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_quiet("rst_mid");
    rst = 1'b0;
    #1;
    chk("rst_mid.ready", {31'b0, req_ready}, 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("rst_mid.mv_n", mv_n - mv0, 32'd1);
    chk("rst_mid.rsp_n", rsp_n - rs0, 32'd0);
    chk("rst_mid.m_we", {31'b0, mv_we}, 32'd0);

    run_vec(vecs[0]);
    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
